pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Parametrised pipeline fence between CPU stages (FE/DE, DE/EX, EX/MEM, MEM/WB).
- Successor to the stall-only pipe register. Adds a valid/ready handshake, synchronous flush for branch/trap squash, and an optional 2-entry skid buffer.
- The skid buffer removes the combinational ready path between stages.
- Adds an occupancy output and a saturating stall counter for performance debug.

Parameters:
- WIDTH, 32, payload width in bits (1..256).
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low (sampled on rising clk edge; 0 = reset)
- flush  in  1  squash all held entries; synchronous
- in_valid  in  1  upstream payload valid
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready
- out_valid  out  1  downstream payload valid
- out_data  out  WIDTH  downstream payload
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready
- occ  out  2  entries held (0..2; 0..1 when SKID=0)
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Reset (reset==0 at an edge):
  - After the edge: out_valid=0, out_data=0, occ=0, stall_cnt=0, skid entry invalid.
  - in_ready=0 while reset is asserted; in_ready=1 on the first cycle after release.
  - Reset mid-transfer drops all held data.
- Latency and throughput: latency is exactly 1 cycle from an input transfer to out_valid (EMPTY case). Full throughput is 1 transfer/cycle in both modes.
- Ordering and stability:
  - Strict FIFO order; no payload is duplicated or lost except by flush or reset.
  - While out_valid && !out_ready, out_data and out_valid hold stable.
- SKID=0:
  - Single register. in_ready = !out_valid || out_ready (combinational).
  - On an input transfer: out_data<=in_data, out_valid<=1.
  - Else on an output transfer: out_valid<=0.
- SKID=1: in_ready = (state != SKID), driven from a flop. There is no combinational path from out_ready to in_ready.
- SKID=1 state machine (main register feeds out_data; skid register is the overflow):
  - EMPTY (occ=0):
    - in xfer -> FULL, main<=in_data.
  - FULL (occ=1):
    - in xfer and out xfer -> FULL, main<=in_data.
    - in xfer, no out xfer -> SKID, skid<=in_data.
    - out xfer only -> EMPTY.
    - neither -> FULL.
  - SKID (occ=2, in_ready=0):
    - out xfer -> FULL, main<=skid.
    - else hold.
- Flush:
  - Priority: reset > flush > normal.
  - With flush=1 at an edge, the next state is EMPTY with occ=0 and out_valid=0.
  - An input presented in the flush cycle is consumed (in_ready as normal) and discarded.
  - An output transfer in the flush cycle still counts as delivered.
  - out_data is not cleared by flush; it is don't-care while out_valid=0.
- stall_cnt:
  - Increments by 1 each cycle with out_valid && !out_ready and flush==0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- occ: registered; always equals the number of valid entries. Never exceeds 2 (or 1 when SKID=0).
- Simultaneous in/out transfers in FULL keep occ unchanged. The outgoing word is the old main; the new word follows on the next cycle.

Test Plan:
- Reset, then stream: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=0, occ=0. Release reset, feed 0x11,0x22,0x33 back-to-back with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first accept; occ stays 1.
- Backpressure (SKID=1): out_ready=0, send 0xA then 0xB -> occ=2 and in_ready=0 the cycle after 0xB; out_data holds 0xA. Raise out_ready -> 0xA, then 0xB, then out_valid=0; in_ready returns 1 one cycle after 0xA leaves.
- Combinational ready (SKID=0): FULL with out_ready toggled 0/1 each cycle -> in_ready mirrors out_ready in the same cycle; no data is lost over 16 random words, checked against a scoreboard.
- Flush: in SKID state (occ=2) assert flush for 1 cycle with in_valid=1 and data 0xC -> next cycle out_valid=0, occ=0. 0xC never appears; the next word sent emerges normally.
- Stall counter: set CNT_W=4 and hold out_valid with out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Flush leaves it at 15; reset clears it to 0.
- Reset mid-operation: occ=2, then pulse reset=0 for 1 cycle -> out_valid=0 and occ=0 after the edge. Neither held word appears; stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline fence with optional two-entry skid buffer,
// synchronous flush, occupancy output and saturating stall counter.
module pipe_stage_hs #(
  parameter int WIDTH = 32,
  parameter bit SKID  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_xfer, out_xfer, stall;

  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

  // Skid mode takes ready from a flop so out_ready never reaches in_ready.
  assign in_ready = reset &&
    (SKID ? rdy_q : (!out_valid || out_ready));

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign stall    = out_valid && !out_ready && !flush;

  always_comb begin
    occ = 2'd0;
    unique case (1'b1)
      (state_q == S_SKID): occ = 2'd2;
      (state_q == S_FULL): occ = 2'd1;
      default:             occ = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d = S_FULL;
          main_d  = in_data;
        end
      end
      S_FULL: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = S_SKID;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_SKID: begin
        if (out_xfer) begin
          state_d = S_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Squash leaves data regs alone; they are don't-care while invalid.
    if (flush) begin
      state_d = S_EMPTY;
    end
    rdy_d = (state_d != S_SKID);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: vector table plus scoreboards on a
// SKID=1 (CNT_W=4) instance and a SKID=0 instance sharing stimulus.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall_cnt;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_stall_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  pipe_stage_hs #(.WIDTH(32), .SKID(1'b1), .CNT_W(4)) u_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_data  (a_out_data),
    .out_ready (out_ready),
    .occ       (a_occ),
    .stall_cnt (a_stall_cnt)
  );

  pipe_stage_hs #(.WIDTH(32), .SKID(1'b0), .CNT_W(16)) u_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_ready (out_ready),
    .occ       (b_occ),
    .stall_cnt (b_stall_cnt)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [1:0]  occ;
    logic [3:0]  cnt;
    logic [31:0] od;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard update for the edge that follows this mid-cycle sample.
  task automatic sb_one(input string nm, input logic ov,
                        input logic [31:0] od, input logic ir,
                        inout logic [31:0] q[$]);
    logic [31:0] e;
    if (!reset) begin
      q.delete();
    end else begin
      if (ov === 1'b1 && out_ready) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL %s_sb: got %0h expected no word", nm, od);
        end else begin
          e = q.pop_front();
          if (od !== e) begin
            nerr++;
            $display("FAIL %s_sb: got %0h expected %0h", nm, od, e);
          end
        end
      end
      if (flush) q.delete();
      else if (in_valid && ir === 1'b1) q.push_back(in_data);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
    @(posedge clk);
    #1;
    reset = r;
    flush = f;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    @(negedge clk);
    sb_one("a", a_out_valid, a_out_data, a_in_ready, qa);
    sb_one("b", b_out_valid, b_out_data, b_in_ready, qb);
  endtask

  logic [31:0] words[16];

  initial begin
    tbl[0]  = '{0, 0, 1, 'h99, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 'h98, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 'h11, 1, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 'h22, 1, 1, 1, 1, 0, 'h11};
    tbl[4]  = '{1, 0, 1, 'h33, 1, 1, 1, 1, 0, 'h22};
    tbl[5]  = '{1, 0, 0, 0, 1, 1, 1, 1, 0, 'h33};
    tbl[6]  = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 'hA, 0, 0, 1, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 'hB, 0, 1, 1, 1, 0, 'hA};
    tbl[9]  = '{1, 0, 0, 0, 0, 1, 0, 2, 1, 'hA};
    tbl[10] = '{1, 0, 0, 0, 1, 1, 0, 2, 2, 'hA};
    tbl[11] = '{1, 0, 0, 0, 1, 1, 1, 1, 2, 'hB};
    tbl[12] = '{1, 0, 0, 0, 1, 0, 1, 0, 2, 0};
    tbl[13] = '{1, 0, 1, 'hD1, 0, 0, 1, 0, 2, 0};
    tbl[14] = '{1, 0, 1, 'hD2, 0, 1, 1, 1, 2, 'hD1};
    tbl[15] = '{1, 1, 1, 'hC, 0, 1, 0, 2, 3, 'hD1};
    tbl[16] = '{1, 0, 1, 'hE, 1, 0, 1, 0, 3, 0};
    tbl[17] = '{1, 0, 0, 0, 1, 1, 1, 1, 3, 'hE};
    tbl[18] = '{1, 0, 0, 0, 1, 0, 1, 0, 3, 0};
    tbl[19] = '{1, 0, 1, 'hF1, 0, 0, 1, 0, 3, 0};
    tbl[20] = '{1, 1, 1, 'hC2, 1, 1, 1, 1, 3, 'hF1};
    tbl[21] = '{1, 0, 0, 0, 1, 0, 1, 0, 3, 0};

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("row%0d_ov", i), a_out_valid, tbl[i].ov);
      chk($sformatf("row%0d_ir", i), a_in_ready, tbl[i].ir);
      chk($sformatf("row%0d_occ", i), a_occ, tbl[i].occ);
      chk($sformatf("row%0d_cnt", i), a_stall_cnt, tbl[i].cnt);
      if (tbl[i].ov)
        chk($sformatf("row%0d_od", i), a_out_data, tbl[i].od);
    end

    // Stall counter saturation, then flush keeps it.
    step(1, 0, 1, 32'h55, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
    chk("sat_cnt", a_stall_cnt, 4'd15);
    chk("sat_hold_od", a_out_data, 32'h55);
    chk("sat_hold_ov", a_out_valid, 1'b1);
    step(1, 1, 0, 0, 0);
    chk("flush_cnt", a_stall_cnt, 4'd15);
    step(1, 0, 0, 0, 0);
    chk("post_flush_ov", a_out_valid, 1'b0);
    chk("post_flush_occ", a_occ, 2'd0);
    chk("post_flush_cnt", a_stall_cnt, 4'd15);

    // Reset pulse with two held words.
    step(1, 0, 1, 32'h66, 0);
    step(1, 0, 1, 32'h77, 0);
    step(1, 0, 0, 0, 0);
    chk("pre_rst_occ", a_occ, 2'd2);
    chk("pre_rst_ir", a_in_ready, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("in_rst_ir", a_in_ready, 1'b0);
    step(1, 0, 0, 0, 1);
    chk("rst_ov", a_out_valid, 1'b0);
    chk("rst_occ", a_occ, 2'd0);
    chk("rst_cnt", a_stall_cnt, 4'd0);
    chk("rst_ir", a_in_ready, 1'b1);
    chk("rst_b_cnt", b_stall_cnt, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1);
      chk("rst_no_old", a_out_valid, 1'b0);
    end

    // SKID=0: ready follows out_ready combinationally while full.
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    begin
      int k = 0;
      int c = 0;
      while (k < 16 && c < 200) begin
        step(1, 0, 1, words[k], c[0]);
        if (b_out_valid === 1'b1)
          chk("b_ready_mirror", b_in_ready, out_ready);
        if (b_in_ready === 1'b1) k++;
        c++;
      end
      chk("b_words_sent", k, 16);
    end

    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    chk("a_sb_empty", qa.size(), 0);
    chk("b_sb_empty", qb.size(), 0);
    chk("a_drained", a_out_valid, 1'b0);
    chk("b_drained", b_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
